// File: rtl/hv_cmd_pkg.sv
// -----------------------------------------------------------------------------
// hv_cmd_pkg
// Shared definitions for the hv_commandQ consumer side: bus widths, the BSM
// opcode set, CDB field offsets and the fetcher FSM state encoding.
// Imported by hv_cmd_fetcher_if, hv_cdb_checksum and hv_cmd_fetcher.
// -----------------------------------------------------------------------------
package hv_cmd_pkg;

  // Beat width of the hv_commandQ cmd_out port and size of one CDB.
  localparam int CMD_IO_WIDTH = 64;
  localparam int CDB_WIDTH    = 256;
  localparam int BEATS        = CDB_WIDTH / CMD_IO_WIDTH;

  // Default cycles to wait for cmd_oe after a request.
  localparam int OE_TIMEOUT_DEFAULT = 64;

  // Opcodes understood by the BSM engine.
  localparam logic [7:0] BSM_WRITE = 8'h40;
  localparam logic [7:0] BSM_READ  = 8'h30;
  localparam logic [7:0] QUERY     = 8'h70;

  // CDB field offsets. The checksum lives in 32b word 4 (cdb[159:128]);
  // it is chosen so every byte lane XORs to zero over all eight words.
  localparam int OPCODE_LSB = 0;
  localparam int TAG_LSB    = 8;
  localparam int CSUM_WORD  = 4;
  localparam int CSUM_WORDS = CDB_WIDTH / 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT_OE = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4
  } fetch_state_e;

  function automatic logic is_known_opcode(input logic [7:0] op);
    return (op == BSM_WRITE) || (op == BSM_READ) || (op == QUERY);
  endfunction

endpackage

// File: rtl/hv_cmd_fetcher_if.sv
// -----------------------------------------------------------------------------
// hv_cmd_fetcher_if
// Groups the queue-side (request/burst) and dispatcher-side (CDB handshake)
// signals of the command fetcher.
//   master : the fetcher  (drives cmd_request and all cdb_* / status outputs)
//   slave  : environment  (hv_commandQ output port + command dispatcher)
// Signals: enable, cq_cout_ready, cmd_request, cmd_oe, cmd_out[63:0],
//          cdb_valid, cdb_ready, cdb[255:0], cdb_opcode, cdb_tag, cdb_csum_ok,
//          cdb_bad_op, oe_timeout, cmd_count[15:0], csum_err_count[7:0]
// -----------------------------------------------------------------------------
interface hv_cmd_fetcher_if;
  import hv_cmd_pkg::*;

  logic                    enable;
  logic                    cq_cout_ready;
  logic                    cmd_request;
  logic                    cmd_oe;
  logic [CMD_IO_WIDTH-1:0] cmd_out;
  logic                    cdb_valid;
  logic                    cdb_ready;
  logic [CDB_WIDTH-1:0]    cdb;
  logic [7:0]              cdb_opcode;
  logic [7:0]              cdb_tag;
  logic                    cdb_csum_ok;
  logic                    cdb_bad_op;
  logic                    oe_timeout;
  logic [15:0]             cmd_count;
  logic [7:0]              csum_err_count;

  modport master (
    input  enable, cq_cout_ready, cmd_oe, cmd_out, cdb_ready,
    output cmd_request, cdb_valid, cdb, cdb_opcode, cdb_tag, cdb_csum_ok,
           cdb_bad_op, oe_timeout, cmd_count, csum_err_count
  );

  modport slave (
    output enable, cq_cout_ready, cmd_oe, cmd_out, cdb_ready,
    input  cmd_request, cdb_valid, cdb, cdb_opcode, cdb_tag, cdb_csum_ok,
           cdb_bad_op, oe_timeout, cmd_count, csum_err_count
  );

endinterface

// File: rtl/hv_cdb_checksum.sv
// -----------------------------------------------------------------------------
// hv_cdb_checksum
// Combinational CDB checksum check, shared with the host-side CDB builder.
// XOR-folds the eight 32b words of a CDB; each of the four byte lanes of the
// fold must be zero for the CDB to be accepted.
//   i_cdb      in  256  CDB to verify
//   o_csum_ok  out 1    1 = all four byte lanes fold to zero
// -----------------------------------------------------------------------------
module hv_cdb_checksum
  import hv_cmd_pkg::*;
(
  input  logic [CDB_WIDTH-1:0] i_cdb,
  output logic                 o_csum_ok
);

  logic [31:0] w_fold;

  // NOTE: w_fold gets a default before the loop so this block stays purely
  // combinational and never infers a latch.
  always_comb begin
    w_fold = '0;
    for (int w = 0; w < CSUM_WORDS; w++) begin
      w_fold = w_fold ^ i_cdb[w*32 +: 32];
    end
  end

  // Lane-wise zero check collapses to a whole-word zero check.
  assign o_csum_ok = (w_fold == '0);

endmodule

// File: rtl/hv_cmd_fetcher.sv
// -----------------------------------------------------------------------------
// hv_cmd_fetcher
// Consumer-side engine for hv_commandQ. Pulses cmd_request, deserialises the
// 4x64b cmd_out burst into a 256b CDB, verifies its checksum, decodes
// opcode/tag and presents the CDB to the dispatcher with a valid/ready
// handshake.
//   clk    in   clock
//   reset  in   asynchronous, active-high
//   bus    hv_cmd_fetcher_if.master (queue side + dispatcher side)
// Flow: IDLE -> REQ -> WAIT_OE -> CAPTURE -> PRESENT -> IDLE.
// -----------------------------------------------------------------------------
module hv_cmd_fetcher
  import hv_cmd_pkg::*;
#(
  parameter int OE_TIMEOUT = OE_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  hv_cmd_fetcher_if.master  bus
);

  localparam int TIMER_W = $clog2(OE_TIMEOUT);
  localparam int IDX_W   = $clog2(BEATS);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(OE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(BEATS - 1);

  fetch_state_e         r_state;
  fetch_state_e         w_next_state;
  logic [TIMER_W-1:0]   r_timer;
  logic [IDX_W-1:0]     r_beat_idx;
  logic [CDB_WIDTH-1:0] r_cdb;
  logic                 r_cdb_valid;
  logic                 r_csum_ok;
  logic                 r_bad_op;
  logic [15:0]          r_cmd_count;
  logic [7:0]           r_csum_err_count;

  logic                 w_cmd_request;
  logic                 w_oe_timeout;
  logic                 w_last_beat;
  logic                 w_csum_ok;
  logic [CDB_WIDTH-1:0] w_cdb_final;

  assign w_last_beat = (r_state == ST_CAPTURE) && (r_beat_idx == IDX_LAST);

  // The checksum is judged on the CDB as it will look after the last beat
  // lands, so the flag is registered together with cdb_valid.
  assign w_cdb_final = {bus.cmd_out, r_cdb[CDB_WIDTH-CMD_IO_WIDTH-1:0]};

  hv_cdb_checksum u_checksum (
    .i_cdb     (w_cdb_final),
    .o_csum_ok (w_csum_ok)
  );

  // Next-state and strobe decode.
  always_comb begin
    w_next_state  = r_state;
    w_cmd_request = 1'b0;
    w_oe_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable && bus.cq_cout_ready) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        w_cmd_request = 1'b1;
        w_next_state  = ST_WAIT_OE;
      end
      ST_WAIT_OE: begin
        // A beat arriving on the very last wait cycle still wins.
        if (bus.cmd_oe) begin
          w_next_state = ST_CAPTURE;
        end else if (r_timer == TIMER_LAST) begin
          w_oe_timeout = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (r_beat_idx == IDX_LAST) w_next_state = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.cdb_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_timer          <= '0;
      r_beat_idx       <= '0;
      // NOTE: the CDB holding register is reset on purpose: downstream sees
      // a defined all-zero cdb after reset rather than stale burst data.
      r_cdb            <= '0;
      r_cdb_valid      <= 1'b0;
      r_csum_ok        <= 1'b0;
      r_bad_op         <= 1'b0;
      r_cmd_count      <= '0;
      r_csum_err_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_timer <= (r_state == ST_WAIT_OE) ? r_timer + TIMER_W'(1) : '0;

      case (r_state)
        ST_WAIT_OE: begin
          if (bus.cmd_oe) begin
            r_cdb[CMD_IO_WIDTH-1:0] <= bus.cmd_out;
            r_beat_idx              <= IDX_W'(1);
          end
        end
        ST_CAPTURE: begin
          // Beats 1..3 follow beat 0 back-to-back; cmd_oe is not consulted.
          r_cdb[int'(r_beat_idx)*CMD_IO_WIDTH +: CMD_IO_WIDTH] <= bus.cmd_out;
          r_beat_idx <= r_beat_idx + IDX_W'(1);
          if (w_last_beat) begin
            r_cdb_valid <= 1'b1;
            r_csum_ok   <= w_csum_ok;
            r_bad_op    <= !is_known_opcode(r_cdb[OPCODE_LSB +: 8]);
          end
        end
        ST_PRESENT: begin
          // Bad-checksum and bad-opcode CDBs are delivered like any other.
          if (bus.cdb_ready) begin
            r_cdb_valid <= 1'b0;
            r_cmd_count <= r_cmd_count + 16'd1;
            if (!r_csum_ok && (r_csum_err_count != 8'hFF)) begin
              r_csum_err_count <= r_csum_err_count + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_request    = w_cmd_request;
  assign bus.oe_timeout     = w_oe_timeout;
  assign bus.cdb_valid      = r_cdb_valid;
  assign bus.cdb            = r_cdb;
  assign bus.cdb_opcode     = r_cdb[OPCODE_LSB +: 8];
  assign bus.cdb_tag        = r_cdb[TAG_LSB +: 8];
  assign bus.cdb_csum_ok    = r_csum_ok;
  assign bus.cdb_bad_op     = r_bad_op;
  assign bus.cmd_count      = r_cmd_count;
  assign bus.csum_err_count = r_csum_err_count;

endmodule

// File: tb/tb_hv_cmd_fetcher.sv
// -----------------------------------------------------------------------------
// tb_hv_cmd_fetcher
// Self-checking bench for hv_cmd_fetcher: a table of directed CDBs, hand
// sequences for timeout / enable drop / async reset, and random CDBs checked
// against a byte-lane reference model of the checksum and opcode rules.
// -----------------------------------------------------------------------------
module tb_hv_cmd_fetcher;
  import hv_cmd_pkg::*;

  logic clk = 1'b0;
  logic reset;

  hv_cmd_fetcher_if bus ();

  hv_cmd_fetcher dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] cdb;
    int           oe_dly;
    int           rdy_dly;
    logic [7:0]   op;
    logic [7:0]   tag;
    logic         ok;
    logic         bad;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  int req_pulses = 0;
  int to_pulses  = 0;
  int exp_count  = 0;
  int exp_err    = 0;

  always @(negedge clk) begin
    if (bus.cmd_request === 1'b1) req_pulses++;
    if (bus.oe_timeout === 1'b1) to_pulses++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte b of the CDB belongs to lane b%4; every lane must
  // XOR to zero across the whole CDB.
  function automatic logic ref_csum_ok(input logic [255:0] c);
    logic [7:0] lane [4];
    for (int k = 0; k < 4; k++) lane[k] = 8'h00;
    for (int b = 0; b < 32; b++) lane[b % 4] ^= c[b*8 +: 8];
    return (lane[0] == 8'h00) && (lane[1] == 8'h00) && (lane[2] == 8'h00) && (lane[3] == 8'h00);
  endfunction

  function automatic logic ref_bad_op(input logic [7:0] op);
    return !(op == 8'h40 || op == 8'h30 || op == 8'h70);
  endfunction

  function automatic vec_t mk(input logic [63:0] b3, b2, b1, b0, input int oe_dly, rdy_dly,
                              input logic [7:0] op, tag, input logic ok, bad);
    vec_t v;
    v.cdb = {b3, b2, b1, b0};
    v.oe_dly = oe_dly; v.rdy_dly = rdy_dly;
    v.op = op; v.tag = tag; v.ok = ok; v.bad = bad;
    return v;
  endfunction

  // One complete fetch: wait for the request, play the burst oe_dly cycles
  // into WAIT_OE, check the presented CDB, hold ready low rdy_dly cycles,
  // then transfer and check the counters.
  task automatic run_txn(input logic [255:0] c, input int oe_dly, input int rdy_dly,
                         input logic [7:0] e_op, input logic [7:0] e_tag,
                         input logic e_ok, input logic e_bad, input bit drop_en,
                         output int waited);
    int req0;
    waited = 0;
    while (bus.cmd_request !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    check("req_seen", bus.cmd_request, 1'b1);
    if (bus.cmd_request !== 1'b1) return;
    req0 = req_pulses;
    if (drop_en) bus.enable = 1'b0;
    step();
    for (int i = 0; i < oe_dly; i++) begin
      bus.cdb_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.cdb_ready = 1'b0;
    bus.cmd_oe = 1'b1; bus.cmd_out = c[63:0];    step();
    bus.cmd_oe = 1'b0; bus.cmd_out = c[127:64];  step();
    bus.cmd_out = c[191:128];                    step();
    bus.cmd_out = c[255:192];
    check("valid_early", bus.cdb_valid, 1'b0);
    step();
    bus.cmd_out = {$urandom, $urandom};
    check("valid_rise", bus.cdb_valid, 1'b1);
    check("cdb", bus.cdb, c);
    check("opcode", bus.cdb_opcode, e_op);
    check("tag", bus.cdb_tag, e_tag);
    check("csum_ok", bus.cdb_csum_ok, e_ok);
    check("bad_op", bus.cdb_bad_op, e_bad);
    for (int i = 0; i < rdy_dly; i++) begin
      bus.cmd_oe = 1'($urandom_range(0, 1));
      step();
      check("hold", {bus.cdb_valid, bus.cmd_request, bus.cdb}, {1'b1, 1'b0, c});
    end
    bus.cdb_ready = 1'b1;
    bus.cmd_oe = 1'b0;
    step();
    bus.cdb_ready = 1'b0;
    exp_count = (exp_count + 1) % 65536;
    if (!e_ok && exp_err < 255) exp_err++;
    check("valid_drop", bus.cdb_valid, 1'b0);
    check("cmd_count", bus.cmd_count, exp_count);
    check("csum_err_count", bus.csum_err_count, exp_err);
    check("one_request", req_pulses - req0, 1);
  endtask

  vec_t vecs [9];

  initial begin
    int waited;
    int cnt;
    int to0;
    logic [31:0] w [8];
    logic [255:0] c;

    vecs[0] = mk(64'h0, 64'h40,   64'h0, 64'h40,   0,  0, 8'h40, 8'h00, 1'b1, 1'b0);
    vecs[1] = mk(64'h0, 64'h0040, 64'h0, 64'h0040, 0,  0, 8'h40, 8'h00, 1'b1, 1'b0);
    vecs[2] = mk(64'h0, 64'h0140, 64'h0, 64'h0140, 0,  0, 8'h40, 8'h01, 1'b1, 1'b0);
    vecs[3] = mk(64'h0, 64'h0240, 64'h0, 64'h0240, 0,  0, 8'h40, 8'h02, 1'b1, 1'b0);
    vecs[4] = mk(64'h0, 64'h0,    64'h0, 64'h0540, 3,  1, 8'h40, 8'h05, 1'b0, 1'b0);
    vecs[5] = mk(64'h0, 64'h55,   64'h0, 64'h55,   1,  2, 8'h55, 8'h00, 1'b1, 1'b1);
    vecs[6] = mk(64'h1122334455667788, 64'h0930, 64'h1122334455667788, 64'h0930,
                 63, 0, 8'h30, 8'h09, 1'b1, 1'b0);
    vecs[7] = mk(64'h0, 64'h7a70, 64'h0, 64'h7a70, 2, 10, 8'h70, 8'h7a, 1'b1, 1'b0);
    vecs[8] = mk(64'h0, 64'h0,    64'h0, 64'h00FF, 5,  0, 8'hFF, 8'h00, 1'b0, 1'b1);

    reset = 1'b1;
    bus.enable = 1'b0; bus.cq_cout_ready = 1'b0; bus.cmd_oe = 1'b0;
    bus.cmd_out = '0;  bus.cdb_ready = 1'b0;
    step(); step();
    check("rst_valid", bus.cdb_valid, 1'b0);
    check("rst_request", bus.cmd_request, 1'b0);
    check("rst_cdb", bus.cdb, '0);
    check("rst_flags", {bus.cdb_csum_ok, bus.cdb_bad_op, bus.oe_timeout}, 3'b000);
    check("rst_counters", {bus.cmd_count, bus.csum_err_count}, 24'h0);
    reset = 1'b0;
    step();

    // Disabled: queue ready and stray cmd_oe must not start anything.
    bus.cq_cout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cmd_oe = 1'($urandom_range(0, 1));
      bus.cmd_out = {$urandom, $urandom};
      step();
      check("disabled_idle", {bus.cmd_request, bus.cdb_valid}, 2'b00);
    end
    bus.cmd_oe = 1'b0;
    bus.enable = 1'b1;

    // Directed table; back-to-back requests come 2 cycles after a transfer.
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].cdb, vecs[i].oe_dly, vecs[i].rdy_dly, vecs[i].op, vecs[i].tag,
              vecs[i].ok, vecs[i].bad, 1'b0, waited);
      if (i > 0) check("throughput", waited, 1);
    end

    // Enable dropped mid-fetch: CDB completes, then no new request.
    run_txn(vecs[0].cdb, 2, 0, 8'h40, 8'h00, 1'b1, 1'b0, 1'b1, waited);
    for (int i = 0; i < 5; i++) begin
      step();
      check("enable_low_no_req", bus.cmd_request, 1'b0);
    end
    bus.enable = 1'b1;

    // OE timeout: pulse 64 cycles after the request, then re-request.
    to0 = to_pulses;
    cnt = 0;
    while (bus.cmd_request !== 1'b1 && cnt < 50) begin step(); cnt++; end
    check("to_req_seen", bus.cmd_request, 1'b1);
    cnt = 0;
    while (bus.oe_timeout !== 1'b1 && cnt < 100) begin step(); cnt++; end
    check("oe_timeout_delay", cnt, 64);
    check("to_no_valid", bus.cdb_valid, 1'b0);
    step();
    check("to_single_pulse", {bus.oe_timeout, bus.cmd_request}, 2'b00);
    step();
    check("to_rerequest", bus.cmd_request, 1'b1);
    check("to_pulse_count", to_pulses - to0, 1);
    check("to_count_kept", bus.cmd_count, exp_count);
    run_txn(vecs[2].cdb, 0, 0, 8'h40, 8'h01, 1'b1, 1'b0, 1'b0, waited);

    // Random CDBs against the reference model.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 8; k++) w[k] = $urandom;
      case ($urandom_range(0, 3))
        0: w[0][7:0] = 8'h40;
        1: w[0][7:0] = 8'h30;
        2: w[0][7:0] = 8'h70;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        w[CSUM_WORD] = 32'h0;
        for (int k = 0; k < 8; k++) if (k != CSUM_WORD) w[CSUM_WORD] ^= w[k];
      end
      c = {w[7], w[6], w[5], w[4], w[3], w[2], w[1], w[0]};
      run_txn(c, $urandom_range(0, 10), $urandom_range(0, 4), c[7:0], c[15:8],
              ref_csum_ok(c), ref_bad_op(c[7:0]), 1'b0, waited);
    end

    // Async reset in the middle of CAPTURE.
    cnt = 0;
    while (bus.cmd_request !== 1'b1 && cnt < 50) begin step(); cnt++; end
    step();
    bus.cmd_oe = 1'b1; bus.cmd_out = 64'hA5A5_0000_0000_0040; step();
    bus.cmd_oe = 1'b0; bus.cmd_out = 64'h1234_5678_9ABC_DEF0; step();
    #2 reset = 1'b1;
    #1;
    check("midrst_valid_req", {bus.cdb_valid, bus.cmd_request, bus.oe_timeout}, 3'b000);
    check("midrst_cdb", bus.cdb, '0);
    check("midrst_fields", {bus.cdb_opcode, bus.cdb_tag, bus.cdb_csum_ok, bus.cdb_bad_op}, 18'h0);
    check("midrst_counters", {bus.cmd_count, bus.csum_err_count}, 24'h0);
    exp_count = 0;
    exp_err   = 0;
    step();
    reset = 1'b0;
    run_txn(vecs[4].cdb, 1, 1, 8'h40, 8'h05, 1'b0, 1'b0, 1'b0, waited);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
